rca_diff_checker: RTL
=====================

# rca_diff_checker

Self-checking response monitor for the ripple-carry difference unit (`rca_diff`, computes a − b as a + ~b + 1 with cin = 1). On `start` it sweeps every operand pair exhaustively and drives `a`/`b`/`cin` into the adder. It samples `sum`/`cout` back, compares each against the arithmetically expected difference, and reports an error count and the first failing vector. It lives beside the adder in the FPGA design, so hardware can run the sweep on-board instead of relying on simulation-only stimulus.

## Interface
- `WIDTH`, default 8: operand width.
- `SETTLE`, default 1: clocks from operand update to result sample. Must be ≥ 1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request; sampled high for one cycle while not busy.
- `a`  out  WIDTH  minuend to the adder (registered).
- `b`  out  WIDTH  subtrahend to the adder (registered).
- `cin`  out  1  carry-in to the adder; constant 1.
- `sum`  in  WIDTH  adder result.
- `cout`  in  1  adder carry-out.
- `busy`  out  1  high while the sweep runs.
- `done`  out  1  level; high from sweep completion until the next accepted `start` or reset.
- `err_cnt`  out  2·WIDTH+1  count of mismatching vectors; saturates at all-ones.
- `first_err_idx`  out  2·WIDTH  index of the first mismatching vector.
- `err_flag`  out  1  high once any mismatch has been seen in the current sweep.

## Operation
- Reset values:
  - `a`, `b`, `busy`, `done`, `err_cnt`, `first_err_idx`, `err_flag` are all 0.
  - `cin` is 1.
  - FSM is in IDLE.
- FSM states and transitions:
  - IDLE → DRIVE on `start`.
  - DRIVE → WAIT when SETTLE > 1; DRIVE → CHECK when SETTLE = 1.
  - WAIT → CHECK after SETTLE−1 cycles.
  - CHECK → DRIVE when vectors remain; CHECK → DONE after the last vector.
  - DONE → DRIVE on `start`.
- Vector index `idx` is 2·WIDTH bits and runs 0 … 2^(2·WIDTH)−1. The operands are `{b,a} = idx`, so `a` is the low half.
- Expected result:
  - `exp = {1'b0,a} + {1'b0,~b} + 1`, computed WIDTH+1 bits wide.
  - `sum` must equal `exp[WIDTH-1:0]`.
  - `cout` must equal `exp[WIDTH]`, i.e. 1 exactly when a ≥ b unsigned.
- A vector mismatches if either `sum` or `cout` differs. On a mismatch:
  - `err_cnt` increments, saturating.
  - If `err_flag` is 0, `idx` is captured into `first_err_idx` and `err_flag` sets.
- Accepting `start` clears `err_cnt`, `first_err_idx`, `err_flag`, `done` and sets `idx` to 0.
- `start` while `busy` is ignored.
- After the sweep, `a`/`b` hold the last vector driven.
- `rst_n` low mid-sweep forces all reset values immediately. No partial results are retained.

## Timing
- Let E0 be the edge that samples `start`.
- `busy` rises and vector 0 appears on `a`/`b` after E0.
- Vector period is P = SETTLE+1 clocks:
  - vector k is driven at edge E0 + k·P;
  - vector k is compared at edge E0 + k·P + SETTLE.
- The last compare is at E0 + (2^(2·WIDTH)−1)·P + SETTLE.
- At the following edge, `busy` falls and `done` rises, in the same cycle.
- `err_cnt`/`first_err_idx`/`err_flag` update at the compare edge and are visible the next cycle.
- For WIDTH=8, SETTLE=1: `done` rises at E0 + 131072.

## Configuration
- `RCA_DIFF_CHK_STOP_ON_ERR_EN`:
  - Defined: on the first mismatch the FSM goes straight from CHECK to DONE. `err_cnt` = 1, and `a`/`b` keep the failing vector for on-board inspection.
  - Undefined: the sweep always covers all vectors and counts every mismatch.

## Test plan
- Correct behavioural adder, WIDTH=8, SETTLE=1, pulse `start`:
  - `done` rises at E0+131072;
  - `err_cnt`=0, `err_flag`=0, `first_err_idx`=0.
- Adder with `sum[0]` stuck at 0:
  - `err_cnt`=32768 (every odd difference);
  - `first_err_idx`=0x0001 (a=1, b=0);
  - `err_flag`=1.
- Adder with `cout` inverted: `err_cnt`=65536 and `first_err_idx`=0x0000.
- With `RCA_DIFF_CHK_STOP_ON_ERR_EN` and `sum[0]` stuck at 0:
  - `done` rises 4 cycles after E0;
  - `err_cnt`=1, `a`=1, `b`=0 held.
- `start` re-pulsed mid-sweep: ignored, and completion timing is unchanged.
- Then `rst_n` low for 1 cycle at vector 100:
  - all outputs return to reset values at once;
  - a new `start` completes normally with `err_cnt`=0.

Source files
------------

// File: rtl/rca_diff_checker.sv
// Exhaustive on-board sweep checker for the rca_diff subtractor.
// Optional: RCA_DIFF_CHK_STOP_ON_ERR_EN halts the sweep at the first mismatch.
`timescale 1ns/1ps
module rca_diff_checker #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               cin,
  input  logic [WIDTH-1:0]   sum,
  input  logic               cout,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   err_cnt,
  output logic [2*WIDTH-1:0] first_err_idx,
  output logic               err_flag
);

  localparam int IW = 2 * WIDTH;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    IDLE, DRIVE, WAIT, CHECK, DONE
  } state_t;

  state_t          state, nxt;
  logic [SW-1:0]   wcnt;
  logic [WIDTH:0]  exp_d;
  logic            go, cmp, mism, last;

  assign cin  = 1'b1;
  assign busy = (state == DRIVE) || (state == WAIT) || (state == CHECK);
  assign done = (state == DONE);
  assign go   = start && !busy;
  assign last = &{b, a};

  assign exp_d = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign mism  = (sum != exp_d[WIDTH-1:0]) || (cout != exp_d[WIDTH]);

  // compare happens on the edge that leaves the settle window
  assign cmp = ((state == DRIVE) && (SETTLE == 1)) ||
               ((state == WAIT) && (wcnt == SW'(SETTLE - 2)));

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: if (start) nxt = DRIVE;
      DRIVE:      nxt = (SETTLE == 1) ? CHECK : WAIT;
      WAIT:       if (cmp) nxt = CHECK;
      CHECK: begin
`ifdef RCA_DIFF_CHK_STOP_ON_ERR_EN
        nxt = (last || err_flag) ? DONE : DRIVE;
`else
        nxt = last ? DONE : DRIVE;
`endif
      end
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               wcnt <= '0;
    else if (state == DRIVE)  wcnt <= '0;
    else if (state == WAIT)   wcnt <= wcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a             <= '0;
      b             <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      err_flag      <= 1'b0;
    end else begin
      if (go) begin
        {b, a}        <= '0;
        err_cnt       <= '0;
        first_err_idx <= '0;
        err_flag      <= 1'b0;
      end else if (state == CHECK && nxt == DRIVE) begin
        {b, a} <= {b, a} + IW'(1);
      end
      if (cmp && mism) begin
        if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
        if (!err_flag) begin
          first_err_idx <= {b, a};
          err_flag      <= 1'b1;
        end
      end
    end
  end

endmodule
